// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: per-channel synchroniser and stability-window
// debouncer, plus press/release pulses, long-press detection and auto-repeat on a shared tick.
module debounce_bank #(
  parameter int N_BTN        = 4,
  parameter int INTERVAL     = 1000000,
  parameter int TICK_DIV     = 100000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_held,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int CNT_W  = $clog2(INTERVAL + 1);
  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int REP_W  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(INTERVAL);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic [N_BTN-1:0]  sync1_q, sync2_q;
  logic [N_BTN-1:0]  samp_q, samp_d;
  logic [N_BTN-1:0]  state_q, state_d;
  logic [N_BTN-1:0]  press_q, release_q;
  logic [N_BTN-1:0]  long_pulse_q, long_pulse_d;
  logic [N_BTN-1:0]  rep_pulse_q, rep_pulse_d;
  logic [N_BTN-1:0]  held;
  logic [CNT_W-1:0]  cnt_q  [N_BTN];
  logic [CNT_W-1:0]  cnt_d  [N_BTN];
  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];
  logic [REP_W-1:0]  rep_q  [N_BTN];
  logic [REP_W-1:0]  rep_d  [N_BTN];
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      held[i] = (hold_q[i] == HOLD_MAX);
    end
  end

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    for (int i = 0; i < N_BTN; i++) begin
      samp_d[i]       = samp_q[i];
      cnt_d[i]        = cnt_q[i];
      state_d[i]      = state_q[i];
      hold_d[i]       = hold_q[i];
      rep_d[i]        = rep_q[i];
      rep_pulse_d[i]  = 1'b0;
      long_pulse_d[i] = 1'b0;

      if (sync2_q[i] != samp_q[i]) begin
        samp_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] < CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        state_d[i] = samp_q[i];
      end

      // Hold/repeat key off the next debounced level so a release on a tick suppresses pulses.
      if (!state_d[i]) begin
        hold_d[i] = '0;
        rep_d[i]  = '0;
      end else begin
        if (tick && !held[i]) begin
          hold_d[i] = hold_q[i] + HOLD_W'(1);
        end
        if (REPEAT_TICKS == 0 || !held[i]) begin
          rep_d[i] = '0;
        end else if (tick) begin
          if (rep_q[i] == REP_LAST) begin
            rep_d[i]       = '0;
            rep_pulse_d[i] = 1'b1;
          end else begin
            rep_d[i] = rep_q[i] + REP_W'(1);
          end
        end
      end
      long_pulse_d[i] = (hold_d[i] == HOLD_MAX) && !held[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      samp_q       <= '0;
      state_q      <= '0;
      press_q      <= '0;
      release_q    <= '0;
      long_pulse_q <= '0;
      rep_pulse_q  <= '0;
      div_q        <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
        rep_q[i]  <= '0;
      end
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      samp_q       <= samp_d;
      state_q      <= state_d;
      press_q      <= state_d & ~state_q;
      release_q    <= ~state_d & state_q;
      long_pulse_q <= long_pulse_d;
      rep_pulse_q  <= rep_pulse_d;
      div_q        <= div_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
        rep_q[i]  <= rep_d[i];
      end
    end
  end

  assign btn_state     = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_held     = held;
  assign long_pulse    = long_pulse_q;
  assign repeat_pulse  = rep_pulse_q;

endmodule
